control_rw_flow: RTL and testbench

CONTROL_RW_FLOW -- requirements
Module: control_rw_flow

---
 rtl/control_rw_flow.sv | 107 ++++++++++
 tb/tb_control_rw_flow.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/control_rw_flow.sv
// Command flow controller: sequences memory access, shift-register load and serial transmit.
// Optional TX/WAIT watchdog is built only when TX_TIMEOUT_EN is defined.
module control_rw_flow #(
    parameter int unsigned TX_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic valid_cmd,
    input  logic rw,
    input  logic active,
    input  logic mode,
    input  logic tx_done,
    output logic ac_mem,
    output logic rw_mem,
    output logic p_load,
    output logic tx_dat,
    output logic busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM,
        S_LOAD,
        S_TX,
        S_WAIT
    } state_e;

    state_e state_q, state_d;
    logic   rw_q, rw_d;

`ifdef TX_TIMEOUT_EN
    localparam int unsigned CW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
`else
    logic unused_cfg;
    assign unused_cfg = ^TX_TIMEOUT;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rw_q    <= 1'b0;
`ifdef TX_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
`ifdef TX_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
`ifdef TX_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        ac_mem  = 1'b0;
        rw_mem  = 1'b0;
        p_load  = 1'b0;
        tx_dat  = 1'b0;
        busy    = (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (active && valid_cmd) begin
                    rw_d    = rw;
                    state_d = mode ? S_MEM : S_LOAD;
                end
            end
            S_MEM: begin
                ac_mem  = 1'b1;
                rw_mem  = rw_q;
                state_d = rw_q ? S_IDLE : S_LOAD;
            end
            S_LOAD: begin
                p_load  = 1'b1;
                state_d = S_TX;
`ifdef TX_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_TX: begin
                tx_dat = 1'b1;
                // a done level left over from the previous frame is not an acceptance
                if (!tx_done) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef TX_TIMEOUT_EN
        if (state_q == S_TX || state_q == S_WAIT) begin
            if (cnt_q == CW'(TX_TIMEOUT - 1)) state_d = S_IDLE;
            else                              cnt_d   = cnt_q + 1'b1;
        end
`endif

        if (state_q != S_IDLE && !active) state_d = S_IDLE;
    end

endmodule

// File: tb/tb_control_rw_flow.sv
// Bench for control_rw_flow: random command transactions expanded into expected output traces.
module tb_control_rw_flow;

    logic clk = 1'b0;
    logic reset, valid_cmd, rw, active, mode, tx_done;
    logic ac_mem, rw_mem, p_load, tx_dat, busy;
    logic [4:0] out_v;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    control_rw_flow #(.TX_TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .valid_cmd(valid_cmd), .rw(rw),
        .active(active), .mode(mode), .tx_done(tx_done),
        .ac_mem(ac_mem), .rw_mem(rw_mem), .p_load(p_load),
        .tx_dat(tx_dat), .busy(busy)
    );

    assign out_v = {ac_mem, rw_mem, p_load, tx_dat, busy};

    // expected output patterns {ac_mem, rw_mem, p_load, tx_dat, busy}
    localparam logic [4:0] O_IDLE = 5'b00000;
    localparam logic [4:0] O_MEMW = 5'b11001;
    localparam logic [4:0] O_MEMR = 5'b10001;
    localparam logic [4:0] O_LOAD = 5'b00101;
    localparam logic [4:0] O_TX   = 5'b00011;
    localparam logic [4:0] O_WAIT = 5'b00001;

    typedef struct packed {
        logic       v, r, a, m, t;
        logic [4:0] exp;
    } step_t;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic step_t mk(logic v, logic r, logic a, logic m, logic t, logic [4:0] exp);
        step_t s;
        s.v = v; s.r = r; s.a = a; s.m = m; s.t = t; s.exp = exp;
        return s;
    endfunction

    task automatic check(input string tag, input logic [4:0] exp);
        n_tests++;
        assert (out_v === exp) else begin
            n_fail++;
            $error("FAIL %s: outputs %b, expected %b", tag, out_v, exp);
        end
    endtask

    task automatic run_step(input string tag, input step_t s);
        valid_cmd = s.v; rw = s.r; active = s.a; mode = s.m; tx_done = s.t;
        @(posedge clk);
        #1;
        check(tag, s.exp);
    endtask

    // One command as the sequence of inputs and the outputs each edge should produce.
    task automatic run_txn();
        step_t       tq[$];
        int unsigned kind, j;
        kind = $urandom_range(0, 2);
        case (kind)
            0: begin
                tq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, rb(), O_MEMW));
                tq.push_back(mk(rb(), rb(), 1'b1, rb(), rb(), O_IDLE));
            end
            default: begin
                if (kind == 1) begin
                    tq.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, rb(), O_MEMR));
                    tq.push_back(mk(rb(), rb(), 1'b1, rb(), rb(), O_LOAD));
                end else begin
                    tq.push_back(mk(1'b1, rb(), 1'b1, 1'b0, rb(), O_LOAD));
                end
                tq.push_back(mk(rb(), rb(), 1'b1, rb(), rb(), O_TX));
                repeat ($urandom_range(0, 3)) tq.push_back(mk(rb(), rb(), 1'b1, rb(), 1'b1, O_TX));
                tq.push_back(mk(rb(), rb(), 1'b1, rb(), 1'b0, O_WAIT));
                repeat ($urandom_range(0, 3)) tq.push_back(mk(rb(), rb(), 1'b1, rb(), 1'b0, O_WAIT));
                tq.push_back(mk(rb(), rb(), 1'b1, rb(), 1'b1, O_IDLE));
            end
        endcase
        if ($urandom_range(0, 3) == 0) begin
            j = $urandom_range(1, tq.size() - 1);
            tq[j].a   = 1'b0;
            tq[j].exp = O_IDLE;
            while (tq.size() > j + 1) void'(tq.pop_back());
        end
        foreach (tq[i]) run_step($sformatf("txn_k%0d_s%0d", kind, i), tq[i]);
        // optional idle gap; a valid command with active low must be refused
        repeat ($urandom_range(0, 2)) begin
            logic v;
            v = rb();
            run_step("idle_gap", mk(v, rb(), v ? 1'b0 : rb(), rb(), rb(), O_IDLE));
        end
    endtask

    initial begin
        reset = 1'b0; valid_cmd = 1'b1; rw = 1'b1; active = 1'b1; mode = 1'b1; tx_done = 1'b1;
        #1;
        check("reset_async", O_IDLE);
        @(posedge clk); #1;
        check("reset_hold", O_IDLE);

        @(negedge clk);
        reset = 1'b1;
        valid_cmd = 1'b0;
        @(posedge clk); #1;
        check("post_reset_idle", O_IDLE);

        // directed memory write, then direct transmit with valid held and immediate re-accept
        run_step("wr_mem", mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, O_MEMW));
        run_step("wr_done", mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, O_IDLE));
        run_step("dt_load", mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, O_LOAD));
        run_step("dt_tx", mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, O_TX));
        run_step("dt_stale", mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, O_TX));
        run_step("dt_w0", mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_WAIT));
        run_step("dt_w1", mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_WAIT));
        run_step("dt_w2", mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_WAIT));
        run_step("dt_idle", mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, O_IDLE));
        run_step("dt_reaccept", mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, O_LOAD));
        run_step("dt2_tx", mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, O_TX));
        run_step("dt2_wait", mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_WAIT));
        run_step("abort_wait", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE));

        for (int n = 0; n < 60; n++) run_txn();

        // reset in the middle of a transmit
        run_step("mid_load", mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, O_LOAD));
        run_step("mid_tx", mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, O_TX));
        #1 reset = 1'b0;
        #1 check("reset_mid_async", O_IDLE);
        @(posedge clk); #1;
        check("reset_mid_hold", O_IDLE);
        @(negedge clk);
        reset = 1'b1;
        run_step("first_accept", mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, O_MEMW));
        run_step("first_done", mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, O_IDLE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
